// File: rtl/mem_arbn.sv
// mem_arbn: N-channel arbiter onto one memory bus; low addresses hit an internal mirrored RAM, the rest go external with timeout.
// Internal ack 2 cycles after the grant, external ack the cycle after memack; losing channels hold chreq until their own chack.
module mem_arbn #(
   parameter int            NCH     = 2,
   parameter int            AW      = 16,
   parameter int            DW      = 8,
   parameter int            RAMAW   = 11,
   parameter logic [AW-1:0] RAMLIM  = AW'(16'h2000),
   parameter int            MODE    = 1,
   parameter int            TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH-1:0]    chreq,
   input  logic [NCH-1:0]    chwr,
   input  logic [NCH*AW-1:0] chaddr,
   input  logic [NCH*DW-1:0] chwdata,
   output logic [NCH-1:0]    chack,
   output logic [DW-1:0]     chrdata,
   output logic              cherr,
   output logic [AW-1:0]     memaddr,
   output logic [DW-1:0]     memwdata,
   output logic              memwr,
   output logic              memreq,
   input  logic              memack,
   input  logic [DW-1:0]     memrdata
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   gnt, ptr, pick, ptr_nxt, offs;
   logic            pick_vld;
   logic [PW:0]     sum;
   logic [2*NCH-1:0] req_rot;
   logic [NCH-1:0]  req_view;
   logic [AW-1:0]   sel_addr, addr;
   logic [DW-1:0]   sel_wdata, wdata, rdata;
   logic            sel_wr, wr, ext, err, tmo_hit;
   logic [TW-1:0]   timer;
   logic [DW-1:0]   ram [0:(1<<RAMAW)-1];

   // Rotate requests so the search always starts at bit 0, then rotate the winner back.
   always_comb begin
      req_rot  = {chreq, chreq} >> ptr;
      req_view = (MODE == 0) ? chreq : req_rot[NCH-1:0];
      offs     = '0;
      pick_vld = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (req_view[k]) begin
            offs     = PW'(k);
            pick_vld = 1'b1;
         end
      end
      if (MODE == 0) sum = {1'b0, offs};
      else           sum = {1'b0, offs} + {1'b0, ptr};
      if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
      pick    = sum[PW-1:0];
      ptr_nxt = (pick == PW'(NCH - 1)) ? '0 : pick + 1'b1;
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (pick == PW'(k)) begin
            sel_addr  = chaddr[k*AW +: AW];
            sel_wdata = chwdata[k*DW +: DW];
            sel_wr    = chwr[k];
         end
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));

   always_comb begin
      state_nxt = state;
      chack     = '0;
      cherr     = 1'b0;
      memreq    = 1'b0;
      memaddr   = '0;
      memwdata  = '0;
      memwr     = 1'b0;
      chrdata   = rdata;
      case (state)
         IDLE: if (pick_vld) state_nxt = BUSY;
         BUSY: begin
            if (ext) begin
               memreq   = 1'b1;
               memaddr  = addr;
               memwdata = wdata;
               memwr    = wr;
            end
            if (!ext || memack || tmo_hit) state_nxt = DONE;
         end
         DONE: begin
            chack     = NCH'(1) << gnt;
            cherr     = err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         addr  <= '0;
         wdata <= '0;
         wr    <= 1'b0;
         ext   <= 1'b0;
         timer <= '0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               timer <= '0;
               err   <= 1'b0;
               if (pick_vld) begin
                  gnt   <= pick;
                  addr  <= sel_addr;
                  wdata <= sel_wdata;
                  wr    <= sel_wr;
                  ext   <= (sel_addr >= RAMLIM);
                  if (MODE != 0) ptr <= ptr_nxt;
               end
            end
            BUSY: begin
               if (ext) begin
                  // memack wins over a timeout landing on the same edge
                  if (memack) begin
                     if (!wr) rdata <= memrdata;
                  end else if (tmo_hit) begin
                     rdata <= '1;
                     err   <= 1'b1;
                  end else if (TIMEOUT != 0) begin
                     timer <= timer + 1'b1;
                  end
               end else if (!wr) begin
                  rdata <= ram[addr[RAMAW-1:0]];
               end
            end
            default: ;
         endcase
      end
   end

   // RAM survives reset; a reset during BUSY leaves state IDLE so no stray write occurs.
   always_ff @(posedge clk) begin
      if (state == BUSY && !ext && wr) ram[addr[RAMAW-1:0]] <= wdata;
   end

endmodule

// File: tb/tb_mem_arbn.sv
// Bench for mem_arbn: directed scenarios with literal expectations, then random traffic against a transaction-level model.
module tb_mem_arbn;
   localparam int NCH = 3;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [2:0]  chreq = '0, chwr = '0;
   logic [47:0] chaddr = '0;
   logic [23:0] chwdata = '0;
   logic [2:0]  chack;
   logic [7:0]  chrdata, memwdata;
   logic        cherr, memwr, memreq;
   logic [15:0] memaddr;
   logic        memack = 1'b0;
   logic [7:0]  memrdata = '0;

   mem_arbn #(.NCH(NCH), .AW(16), .DW(8), .RAMAW(11), .RAMLIM(16'h2000), .MODE(1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn), .chreq(chreq), .chwr(chwr), .chaddr(chaddr), .chwdata(chwdata),
      .chack(chack), .chrdata(chrdata), .cherr(cherr), .memaddr(memaddr), .memwdata(memwdata),
      .memwr(memwr), .memreq(memreq), .memack(memack), .memrdata(memrdata));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: one transfer in flight, completion time derived from cycle arithmetic.
   bit          m_busy = 0, m_ext = 0, m_err = 0;
   int          m_ch = 0, m_start = 0, m_ack_cyc = -1, m_next_arb = 0, m_ptr = 0, g;
   logic [15:0] m_addr = '0;
   logic        m_wr = 1'b0;
   logic [7:0]  m_wd = '0, m_rdata = '0;
   logic [7:0]  m_ram [2048];
   logic [2:0]  e_chack = '0;
   bit          e_memreq = 0, e_err = 0;

   function automatic int first_at(input int p, input logic [2:0] r);
      for (int k = 0; k < NCH; k++) begin
         if (r[(p + k) % NCH]) return (p + k) % NCH;
      end
      return -1;
   endfunction

   int          mr_cnt = 0, mr_wr_cnt = 0, ack_cnt = 0;
   logic [15:0] mr_addr = '0;
   logic [7:0]  mr_wd = '0;
   logic [2:0]  ack_prev = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         check("rst_chack", chack, 0);
         check("rst_memreq", memreq, 0);
         check("rst_cherr", cherr, 0);
         check("rst_chrdata", chrdata, 0);
         check("rst_memaddr", memaddr, 0);
         m_busy = 0; m_ptr = 0; m_next_arb = 0; m_rdata = '0; m_err = 0;
         e_chack = '0; e_memreq = 0; e_err = 0;
      end else begin
         check("chack", chack, e_chack);
         check("memreq", memreq, e_memreq);
         check("cherr", cherr, e_err);
         check("memwr", memwr, e_memreq && m_wr);
         if (e_chack != 0) check("chrdata", chrdata, m_rdata);
         if (e_memreq) begin
            check("memaddr", memaddr, m_addr);
            check("memwdata", memwdata, m_wd);
         end
         if (m_busy && cyc == m_ack_cyc) begin
            m_busy = 0;
            m_next_arb = cyc + 1;
         end
         if (m_busy && m_ext && m_ack_cyc < 0 && cyc > m_start) begin
            if (memack) begin
               m_ack_cyc = cyc + 1;
               if (!m_wr) m_rdata = memrdata;
            end else if (cyc - m_start - 1 == TMO) begin
               m_ack_cyc = cyc + 1;
               m_rdata = 8'hFF;
               m_err = 1;
            end
         end
         if (!m_busy && cyc >= m_next_arb && chreq != 0) begin
            g = first_at(m_ptr, chreq);
            m_busy = 1; m_ch = g; m_start = cyc; m_ptr = (g + 1) % NCH;
            m_addr = chaddr[g*16 +: 16]; m_wr = chwr[g]; m_wd = chwdata[g*8 +: 8];
            m_ext = (m_addr >= 16'h2000); m_err = 0;
            if (!m_ext) begin
               m_ack_cyc = cyc + 2;
               if (m_wr) m_ram[m_addr[10:0]] = m_wd;
               else m_rdata = m_ram[m_addr[10:0]];
            end else begin
               m_ack_cyc = -1;
            end
         end
         e_chack  = (m_busy && m_ack_cyc == cyc + 1) ? 3'(1 << m_ch) : 3'b000;
         e_err    = (e_chack != 0) && m_err;
         e_memreq = m_busy && m_ext && m_ack_cyc < 0;
      end
      if (memreq) begin
         mr_cnt++;
         if (memwr) mr_wr_cnt++;
         mr_addr = memaddr;
         mr_wd = memwdata;
      end
      if (chack != 0) ack_cnt++;
      ack_prev = chack;
   end

   // External responder: acks after a chosen number of memreq cycles (99 = never).
   int wcnt = 0, target = 0, force_dly = 0;
   always @(posedge clk) begin
      #1;
      if (!rstn || !memreq) begin
         memack = 1'b0;
         wcnt = 0;
      end else begin
         wcnt++;
         if (wcnt == 1) target = (force_dly != 0) ? force_dly : int'($urandom_range(1, 11));
         memack = (wcnt == target);
         memrdata = 8'($urandom);
      end
   end

   task automatic do_txn(input int ch, input logic w, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output logic er, output logic mq);
      int  t0;
      bit  got;
      chwr[ch] = w; chaddr[ch*16 +: 16] = a; chwdata[ch*8 +: 8] = d; chreq[ch] = 1'b1;
      t0 = cyc; got = 0; lat = -1; rd = '0; er = 1'b0; mq = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (chack[ch]) begin
            got = 1; lat = cyc - t0; rd = chrdata; er = cherr; mq = memreq;
         end
      end
      check("txn_acked", 32'(got), 1);
      @(posedge clk); #1;
      chreq[ch] = 1'b0;
   endtask

   int order[$];
   task automatic run_group(input logic [2:0] mask, input int n, input bit keep);
      logic [2:0] drop;
      order.delete();
      chreq = chreq | mask;
      for (int k = 0; k < 200 && order.size() < n; k++) begin
         @(negedge clk);
         drop = '0;
         for (int i = 0; i < NCH; i++) begin
            if (chack[i] && mask[i]) begin
               order.push_back(i);
               drop[i] = !keep;
            end
         end
         @(posedge clk); #1;
         chreq = chreq & ~drop;
      end
      chreq = chreq & ~mask;
      check("group_acks", order.size(), n);
   endtask

   task automatic new_ops(input int i);
      chwr[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
         chaddr[i*16 +: 16] = 16'($urandom_range(0, 3) * 'h800 + $urandom_range(0, 15));
      else
         chaddr[i*16 +: 16] = 16'($urandom_range('h2000, 'hFFFF));
      chwdata[i*8 +: 8] = 8'($urandom);
   endtask

   int         lat, a0;
   logic [7:0] rd;
   logic       er, mq;
   logic [2:0] active = '0;

   initial begin
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 16; i++) do_txn(2, 1'b1, 16'(i), 8'(i * 7 + 3), lat, rd, er, mq);

      // round robin with every channel held: 0,1,2,0,1,2
      for (int i = 0; i < NCH; i++) begin
         chwr[i] = 1'b0;
         chaddr[i*16 +: 16] = 16'(i);
      end
      run_group(3'b111, 6, 1'b1);
      for (int i = 0; i < 6; i++) check("rr_order", order[i], i % 3);

      // mirrored internal RAM
      mr_cnt = 0;
      do_txn(0, 1'b1, 16'h0005, 8'hA5, lat, rd, er, mq);
      check("int_wr_lat", lat, 2);
      do_txn(0, 1'b0, 16'h0805, 8'h00, lat, rd, er, mq);
      check("mirror_rdata", rd, 8'hA5);
      check("int_rd_lat", lat, 2);
      check("int_no_memreq", mr_cnt, 0);

      // pointer at 1: simultaneous ch0/ch1 -> ch1 first
      chwr[1:0] = 2'b00; chaddr[15:0] = 16'h0001; chaddr[31:16] = 16'h0002;
      run_group(3'b011, 2, 1'b0);
      check("ptr1_first", order[0], 1);
      check("ptr1_second", order[1], 0);

      // external write, memack on the 4th memreq cycle
      mr_cnt = 0; mr_wr_cnt = 0; force_dly = 4;
      do_txn(1, 1'b1, 16'h8000, 8'h3C, lat, rd, er, mq);
      check("ext_lat", lat, 5);
      check("ext_memreq_cycles", mr_cnt, 4);
      check("ext_memwr_cycles", mr_wr_cnt, 4);
      check("ext_memaddr", mr_addr, 16'h8000);
      check("ext_memwdata", mr_wd, 8'h3C);

      // timeout
      force_dly = 99;
      do_txn(2, 1'b0, 16'h4000, 8'h00, lat, rd, er, mq);
      check("tmo_lat", lat, TMO + 2);
      check("tmo_err", er, 1);
      check("tmo_rdata", rd, 8'hFF);
      check("tmo_memreq_low", mq, 0);

      // reset during external BUSY (pointer moves to 2 on this grant)
      chwr[1] = 1'b0; chaddr[31:16] = 16'h3000; chreq[1] = 1'b1;
      for (int k = 0; k < 20 && !memreq; k++) begin
         @(posedge clk); #1;
      end
      check("rst_case_memreq_up", memreq, 1);
      repeat (2) @(posedge clk);
      #1 a0 = ack_cnt;
      rstn = 1'b0;
      #1 check("rst_memreq_drop", memreq, 0);
      chreq[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("rst_no_ack", ack_cnt, a0);
      rstn = 1'b1;
      chaddr[31:16] = 16'h0003; chwr[2] = 1'b0; chaddr[47:32] = 16'h0004;
      run_group(3'b110, 2, 1'b0);
      check("post_rst_first", order[0], 1);
      check("post_rst_second", order[1], 2);
      force_dly = 0;

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NCH; i++) begin
            if (active[i] && ack_prev[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  active[i] = 1'b0;
                  chreq[i] = 1'b0;
               end else begin
                  new_ops(i);
               end
            end else if (!active[i] && $urandom_range(0, 3) == 0) begin
               new_ops(i);
               active[i] = 1'b1;
               chreq[i] = 1'b1;
            end
         end
      end
      chreq = '0;
      repeat (30) @(posedge clk);
      #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
